// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO: standard or first-word-fall-through read,
// almost-full/empty thresholds, sticky overflow/underflow flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           din,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           dout,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_THRESH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_overflow;
  logic              r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // A flush cycle swallows both requests, so neither side is accepted.
  assign w_rd_acc = ~clr & rd_en & ~w_empty;
  assign w_wr_acc = ~clr & wr_en & (~w_full | w_rd_acc);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: the storage array has no reset so it maps onto plain RAM; its
  // contents are never observed before a write has filled the slot.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & ~w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en & w_empty)   r_underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to zero while nothing is stored
      // so the output matches its reset value instead of stale RAM.
      assign dout     = w_empty ? '0 : r_mem[r_rd_ptr];
      assign rd_valid = ~w_empty;
    end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      logic              r_rd_valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_dout     <= '0;
          r_rd_valid <= 1'b0;
        end else if (clr) begin
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
        end
      end

      assign dout     = r_dout;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-mode and an FWFT instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0]    s_count, f_count;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a plain queue plus sticky flags.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] sb_std[$];
  logic [DW-1:0] sb_fw[$];
  logic [DW-1:0] m_last;
  bit            m_ovf, m_unf, m_rv;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb_std.delete();
    sb_fw.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_rv   = 1'b0;
  endtask

  // Applies the acceptance rules to the pre-edge model state.
  task automatic model_apply(input bit wr, input logic [DW-1:0] d, input bit rd, input bit c);
    int  n;
    bit  racc, wacc;
    if (c) begin
      m_q.delete();
      sb_fw.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      return;
    end
    n    = m_q.size();
    racc = rd && (n != 0);
    wacc = wr && ((n != DEPTH) || racc);
    if (racc) begin
      m_last = m_q.pop_front();
      sb_std.push_back(m_last);
    end
    if (wacc) begin
      m_q.push_back(d);
      sb_fw.push_back(d);
    end
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && n == 0) m_unf = 1'b1;
    m_rv = racc;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = m_q.size();
    check({tag, "/s_count"}, 32'(s_count), 32'(n));
    check({tag, "/s_full"},  32'(s_full),  32'(n == DEPTH));
    check({tag, "/s_empty"}, 32'(s_empty), 32'(n == 0));
    check({tag, "/s_af"},    32'(s_af),    32'(n >= AF));
    check({tag, "/s_ae"},    32'(s_ae),    32'(n <= AE));
    check({tag, "/s_ovf"},   32'(s_ovf),   32'(m_ovf));
    check({tag, "/s_unf"},   32'(s_unf),   32'(m_unf));
    check({tag, "/s_rv"},    32'(s_rv),    32'(m_rv));
    check({tag, "/s_dout"},  32'(s_dout),  32'(m_last));
    check({tag, "/f_count"}, 32'(f_count), 32'(n));
    check({tag, "/f_full"},  32'(f_full),  32'(n == DEPTH));
    check({tag, "/f_empty"}, 32'(f_empty), 32'(n == 0));
    check({tag, "/f_ovf"},   32'(f_ovf),   32'(m_ovf));
    check({tag, "/f_unf"},   32'(f_unf),   32'(m_unf));
    check({tag, "/f_rv"},    32'(f_rv),    32'(n != 0));
    if (n != 0) check({tag, "/f_dout"}, 32'(f_dout), 32'(m_q[0]));
  endtask

  // Called at posedge+2; drives one cycle of stimulus and checks after the edge.
  task automatic step(input string tag, input bit wr, input logic [DW-1:0] d, input bit rd, input bit c);
    wr_en = wr;
    din   = d;
    rd_en = rd;
    clr   = c;
    model_apply(wr, d, rd, c);
    @(posedge clk);
    #1;
    check_state(tag);
    #1;
  endtask

  // Standard-mode monitor: every rd_valid pulse consumes one expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (s_rv) begin
        if (sb_std.size() == 0) check("std_unexpected_valid", 32'(s_rv), 32'd0);
        else                    check("std_read_data", 32'(s_dout), 32'(sb_std.pop_front()));
      end
    end
  end

  // FWFT monitor: a word is consumed when rd_en meets a valid displayed word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && !clr && rd_en && f_rv) begin
        if (sb_fw.size() == 0) check("fwft_unexpected_pop", 32'(f_rv), 32'd0);
        else                   check("fwft_read_data", 32'(f_dout), 32'(sb_fw.pop_front()));
      end
    end
  end

  initial begin
    rst   = 1'b0;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check_state("in_reset");
    rst = 1'b1;
    check_state("reset_release");

    // Fill, then one write too many.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(s_full), 32'd1);
    step("overflow", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("overflow_set", 32'(s_ovf), 32'd1);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);

    // Read on empty, then flush clears the sticky flags.
    step("underflow", 1'b0, '0, 1'b1, 1'b0);
    check("underflow_set", 32'(s_unf), 32'd1);
    step("clr", 1'b1, 8'h77, 1'b1, 1'b1);
    check("clr_unf", 32'(s_unf), 32'd0);
    check("clr_ovf", 32'(f_ovf), 32'd0);

    // Simultaneous read and write while full.
    for (int i = 0; i < 8; i++) step("refill", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
    check("full_rw_count", 32'(s_count), 32'd8);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0);
    check("aa_last", 32'(s_dout), 32'hAA);

    // Wrap-around with occupancy never above one.
    step("wrap0", 1'b1, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      step("wrap", 1'b1, 8'(i), 1'b1, 1'b0);
      check("wrap_cnt_le1", 32'(s_count <= 4'd1), 32'd1);
    end
    step("wrap_end", 1'b0, '0, 1'b1, 1'b0);
    check("wrap_last", 32'(s_dout), 32'd19);

    // FWFT fall-through of a single word.
    step("clr2", 1'b0, '0, 1'b0, 1'b1);
    step("fw_write", 1'b1, 8'h5A, 1'b0, 1'b0);
    check("fw_5a_dout", 32'(f_dout), 32'h5A);
    check("fw_5a_valid", 32'(f_rv), 32'd1);
    step("fw_read", 1'b0, '0, 1'b1, 1'b0);
    check("fw_empty_after", 32'(f_empty), 32'd1);

    // Randomised traffic with an asynchronous reset mid-burst.
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        step("pre_rst", 1'b1, 8'hC3, 1'b0, 1'b0);
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h55;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("rst_held");
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
      end
      step("rand",
           $urandom_range(0, 99) < 55,
           8'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3);
    end

    step("idle", 1'b0, '0, 1'b0, 1'b0);
    check("std_sb_drained", 32'(sb_std.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Next-generation synchronous FIFO with parametrised data width and depth, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is a drop-in buffering element between producer and consumer blocks in the same clock domain. It is the successor to the fixed-size FIFO and keeps the clk/rst/wr_en/rd_en/din/dout/full/empty/count interface.

Parameters:
DATA_W, 8, data width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
FWFT, 0, 0 = standard read (registered dout, 1-cycle latency); 1 = first-word-fall-through.
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.
Derived: ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
clr  input  1  synchronous flush; empties the FIFO and clears the error flags.
wr_en  input  1  write request.
din  input  DATA_W  write data.
rd_en  input  1  read request.
dout  output  DATA_W  read data.
rd_valid  output  1  dout holds valid read data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  CNT_W  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was dropped.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=0, asynchronous) sets: wr_ptr=0, rd_ptr=0, count=0, dout=0, rd_valid=0, overflow=0, underflow=0. Consequently full=0, empty=1, almost_empty=1, almost_full=(AF_THRESH==0). Memory contents are not reset.
- Reset may assert mid-operation. All state clears immediately, without waiting for clk. Operation resumes on the first rising edge after rst returns to 1.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments and wraps DEPTH-1 -> 0.
- On rd_acc: rd_ptr increments and wraps the same way.
- count: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- full, empty, almost_full and almost_empty are combinational decodes of count.
- Standard mode (FWFT=0):
  - On rd_acc: dout <= mem[rd_ptr] and rd_valid <= 1 on the next edge.
  - On a cycle without rd_acc: rd_valid <= 0 and dout holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as the consume/acknowledge of the displayed word.
  - First write to an empty FIFO is visible on dout 1 cycle after the write edge.
- Simultaneous read and write when empty: only the write is accepted (rd_acc=0); underflow sets.
- Simultaneous read and write when full: both are accepted; count stays at DEPTH.
- overflow sets on wr_en & !wr_acc.
- underflow sets on rd_en & empty.
- overflow and underflow are sticky until clr or rst.
- clr=1 at an edge:
  - pointers, count, overflow, underflow and rd_valid go to 0.
  - Any wr_en/rd_en in the same cycle is ignored and does not set the error flags.
  - dout holds its value.
- Pointer wrap-around has no effect on data ordering. Ordering is strict FIFO across any number of wraps.

Test Plan:
- Reset/idle (DATA_W=8, DEPTH=8, FWFT=0, AF=6, AE=1): hold rst=0, then release -> count=0, empty=1, full=0, almost_empty=1, overflow=0, underflow=0.
- Fill and overflow: write 8'h01..8'h08 on consecutive cycles -> almost_full=1 when count=6, full=1 when count=8. A 9th write of 8'hFF -> overflow=1, count stays 8. Then 8 reads return 01..08 in order with rd_valid 1 cycle after each rd_en.
- Underflow: on an empty FIFO assert rd_en for 1 cycle -> underflow=1, rd_valid=0, count=0. Then pulse clr -> underflow=0.
- Simultaneous operations on a full FIFO: wr_en=rd_en=1 with din=8'hAA -> count stays 8, overflow stays 0. The oldest word is read out, and 8'hAA appears as the 8th subsequent read.
- Wrap-around: run 20 write/read pairs with values 0..19 -> output sequence is 0..19 with no loss. count never exceeds 1.
- FWFT (FWFT=1): write 8'h5A into the empty FIFO -> dout=8'h5A and rd_valid=1 on the next cycle without rd_en. Assert rd_en -> empty=1 on the following cycle. Also assert rst=0 mid-burst -> all outputs return to reset values immediately, without waiting for clk.
